// File: rtl/vga_timing_generator.sv
// Free-running VGA raster timing: h/v counters with registered column/row/enable/sync/frame decodes.
// Latency: all outputs lag the counters by 1 clock; syncs lag by 2 when VGA_SYNC_DELAY_EN is defined.
// Backpressure: none; the raster never stalls and there is no handshake.
module vga_timing_generator #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        vga_clock,
    input  logic        reset,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic        display_enable,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic          SYNC_IDLE = ~SYNC_ACTIVE;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [31:0]   column_q, column_d;
    logic [31:0]   row_q, row_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;

    always_comb begin
        h_d         = h_q + 1'b1;
        v_d         = v_q;
        frame_cnt_d = frame_cnt_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d         = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                v_d = v_q + 1'b1;
            end
        end

        // Output decodes look at the current counters, so they appear one clock later.
        column_d      = 32'(h_q);
        row_d         = 32'(v_q);
        de_d          = (h_q < H_VIS) && (v_q < V_VIS);
        fs_d          = (h_q == '0) && (v_q == '0);
        frame_count_d = frame_cnt_q;
        hsync_d       = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_ACTIVE : SYNC_IDLE;
        vsync_d       = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_ACTIVE : SYNC_IDLE;
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_cnt_q   <= '0;
            column_q      <= '0;
            row_q         <= '0;
            de_q          <= 1'b0;
            fs_q          <= 1'b0;
            frame_count_q <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_cnt_q   <= frame_cnt_d;
            column_q      <= column_d;
            row_q         <= row_d;
            de_q          <= de_d;
            fs_q          <= fs_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign column         = column_q;
    assign row            = row_q;
    assign display_enable = de_q;
    assign frame_start    = fs_q;
    assign frame_count    = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
    // Extra stage lines the syncs up with the renderer's registered colour outputs.
    logic hsync_dly_q, hsync_dly_d;
    logic vsync_dly_q, vsync_dly_d;

    always_comb begin
        hsync_dly_d = hsync_q;
        vsync_dly_d = vsync_q;
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            hsync_dly_q <= SYNC_IDLE;
            vsync_dly_q <= SYNC_IDLE;
        end else begin
            hsync_dly_q <= hsync_dly_d;
            vsync_dly_q <= vsync_dly_d;
        end
    end

    assign vga_hsync = hsync_dly_q;
    assign vga_vsync = vsync_dly_q;
`else
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
`endif

endmodule
